// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage; aligns data-SRAM load data and feeds write-back/forwarding.
// Optional feature macro MS_RDATA_HOLD_EN: hold first-cycle read data so alignment survives any stall.
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ws_allowin,
  output logic         ms_allowin,
  input  logic         es_to_ms_valid,
  input  logic [160:0] es_to_ms_bus,
  input  logic [31:0]  data_sram_rdata,
  output logic         ms_to_ws_valid,
  output logic [154:0] ms_to_ws_bus,
  output logic         ms_ex,
  input  logic         handle_ex,
  output logic [4:0]   ms_fwd_dest,
  output logic [3:0]   ms_fwd_wstrb,
  output logic [31:0]  ms_fwd_data,
  output logic         ms_fwd_is_cp0
);
  localparam int ES_TO_MS_BUS_WD = 161;

  logic                       ms_valid_q, ms_valid_d;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q;
  logic                       accept;
  logic [31:0]                rdata;

  logic        ex, eret, res_from_cp0, res_from_mem;
  logic        lb, lbu, lh, lhu, lwl, lwr, gr_we;
  logic [1:0]  addr_low;
  logic [4:0]  dest;
  logic [31:0] alu_result;

  assign ex           = bus_q[160];
  assign eret         = bus_q[121];
  assign res_from_cp0 = bus_q[79];
  assign res_from_mem = bus_q[78];
  assign addr_low     = bus_q[77:76];
  assign lb           = bus_q[75];
  assign lbu          = bus_q[74];
  assign lh           = bus_q[73];
  assign lhu          = bus_q[72];
  assign lwl          = bus_q[71];
  assign lwr          = bus_q[70];
  assign gr_we        = bus_q[69];
  assign dest         = bus_q[68:64];
  assign alu_result   = bus_q[63:32];

  assign ms_allowin = !ms_valid_q || ws_allowin;
  assign accept     = es_to_ms_valid && ms_allowin;

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (handle_ex)       ms_valid_d = 1'b0;
    else if (ms_allowin) ms_valid_d = es_to_ms_valid;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      ms_valid_q <= ms_valid_d;
      if (accept) bus_q <= es_to_ms_bus;
    end
  end

`ifdef MS_RDATA_HOLD_EN
  // SRAM data is only guaranteed in the first resident cycle, so capture it then.
  logic        first_cycle_q;
  logic [31:0] rdata_hold_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      first_cycle_q <= 1'b0;
      rdata_hold_q  <= '0;
    end else begin
      first_cycle_q <= accept;
      if (first_cycle_q) rdata_hold_q <= data_sram_rdata;
    end
  end

  assign rdata = first_cycle_q ? data_sram_rdata : rdata_hold_q;
`else
  assign rdata = data_sram_rdata;
`endif

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] lwl_data, lwr_data, load_data, final_result;
  logic [3:0]  lwl_mask, lwr_mask, rf_wstrb;

  always_comb begin
    byte_sel = rdata[7:0];
    lwl_data = {rdata[7:0], 24'h0};
    lwr_data = rdata;
    lwl_mask = 4'b1000;
    lwr_mask = 4'b1111;
    case (addr_low)
      2'd1: begin
        byte_sel = rdata[15:8];
        lwl_data = {rdata[15:0], 16'h0};
        lwr_data = {8'h0, rdata[31:8]};
        lwl_mask = 4'b1100;
        lwr_mask = 4'b0111;
      end
      2'd2: begin
        byte_sel = rdata[23:16];
        lwl_data = {rdata[23:0], 8'h0};
        lwr_data = {16'h0, rdata[31:16]};
        lwl_mask = 4'b1110;
        lwr_mask = 4'b0011;
      end
      2'd3: begin
        byte_sel = rdata[31:24];
        lwl_data = rdata;
        lwr_data = {24'h0, rdata[31:24]};
        lwl_mask = 4'b1111;
        lwr_mask = 4'b0001;
      end
      default: ;
    endcase
  end

  assign half_sel = addr_low[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    if (lb)       load_data = {{24{byte_sel[7]}}, byte_sel};
    else if (lbu) load_data = {24'h0, byte_sel};
    else if (lh)  load_data = {{16{half_sel[15]}}, half_sel};
    else if (lhu) load_data = {16'h0, half_sel};
    else if (lwl) load_data = lwl_data;
    else if (lwr) load_data = lwr_data;
  end

  assign final_result = res_from_mem ? load_data : alu_result;

  // Byte strobes let write-back merge partial lwl/lwr words into the old register value.
  always_comb begin
    rf_wstrb = 4'b1111;
    if (ex || !gr_we) rf_wstrb = 4'b0000;
    else if (lwl)     rf_wstrb = lwl_mask;
    else if (lwr)     rf_wstrb = lwr_mask;
  end

  assign ms_to_ws_valid = ms_valid_q;
  assign ms_to_ws_bus   = {bus_q[160:79], rf_wstrb, dest, final_result, bus_q[31:0]};
  assign ms_ex          = ms_valid_q & (ex | eret);
  assign ms_fwd_wstrb   = ms_valid_q ? rf_wstrb : 4'h0;
  assign ms_fwd_dest    = (ms_valid_q && (rf_wstrb != 4'h0) && (dest != 5'd0)) ? dest : 5'd0;
  assign ms_fwd_data    = final_result;
  assign ms_fwd_is_cp0  = ms_valid_q & res_from_cp0;

endmodule
